// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencing controller and its
// hazard comparator.
package pipe_ctrl_pkg;

  localparam int REG_W   = 5;
  localparam int STALL_W = 32;
  localparam int FLUSH_W = 16;
  localparam int WAIT_W  = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use hazard detector: flags an ID source that depends on a load
// still in EX. Kept standalone so the forwarding unit can reuse it.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             hz
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for
  assign hz = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: register enables/flushes for the 5-stage
// core, memory-wait FSM with sticky timeout, and saturating perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               ex_mem_read,
  input  logic               ex_branch_taken,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [STALL_W-1:0] stall_cycles,
  output logic [FLUSH_W-1:0] flush_events,
  output logic               mem_timeout
);

  localparam logic [WAIT_W:0] TIMEOUT_LIMIT = (WAIT_W + 1)'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic              frz;
  logic              hz;
  logic              branch_flush;
  logic              waiting;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;

  hazard_cmp u_hazard_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hz          (hz)
  );

  assign frz          = dmem_req && !dmem_ready;
  assign branch_flush = rst && !frz && ex_branch_taken;
  assign waiting      = (state == MEM_WAIT) && !dmem_ready;
  assign wait_inc     = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Freeze outranks branch, which outranks load-use; reset forces bubbles everywhere.
  always_comb begin
    state_next = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    case (state)
      RUN:      if (frz) state_next = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_next = RUN;
      default:  state_next = RUN;
    endcase

    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (frz) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hz) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // The wait counter only tracks stalled MEM_WAIT cycles; the access itself is never aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (waiting) begin
      wait_cnt <= wait_inc;
      if ({1'b0, wait_inc} >= TIMEOUT_LIMIT) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (branch_flush && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (TIMEOUT=4) with hand-computed
// expectations for stalls, flushes, freezes, timeout and reset.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
  localparam logic [6:0] C_RUN    = 7'b11111_00;
  localparam logic [6:0] C_FREEZE = 7'b00000_00;
  localparam logic [6:0] C_BRANCH = 7'b11111_11;
  localparam logic [6:0] C_LDUSE  = 7'b00111_01;
  localparam logic [6:0] C_RESET  = 7'b00000_11;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        dmem_req, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
  logic        mem_timeout;
  logic [6:0]  ctrl;

  int errors = 0;
  int checks = 0;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    checks++; if (ctrl !== C_RESET) begin errors++; $display("FAIL rst_ctrl: got %b expected %b", ctrl, C_RESET); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_counters: got stall=%0d flush=%0d to=%b expected 0 0 0", stall_cycles, flush_events, mem_timeout);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL rst_release_ctrl: got %b expected %b", ctrl, C_RUN); end
    tick();
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_idle_stall: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctrl !== C_LDUSE) begin errors++; $display("FAIL lu_ctrl: got %b expected %b", ctrl, C_LDUSE); end
    tick();
    idle_inputs();
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL lu_after_ctrl: got %b expected %b", ctrl, C_RUN); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cycles); end
    tick();
  endtask

  task automatic test_no_hazard();
    // {ex_mem_read, ex_rd, use_rs1, rs1, use_rs2, rs2}
    logic [17:0] vec [4];
    vec[0] = {1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0};
    vec[1] = {1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 5'd2};
    vec[2] = {1'b1, 5'd9, 1'b1, 5'd4, 1'b0, 5'd9};
    vec[3] = {1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 5'd6};
    for (int i = 0; i < 4; i++) begin
      {ex_mem_read, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2} = vec[i];
      #1;
      checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL nohz_%0d_ctrl: got %b expected %b", i, ctrl, C_RUN); end
      tick();
    end
    idle_inputs();
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL nohz_stall_cnt: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_branch_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    checks++; if (ctrl !== C_BRANCH) begin errors++; $display("FAIL br_lu_ctrl: got %b expected %b", ctrl, C_BRANCH); end
    tick();
    idle_inputs();
    checks++; if (flush_events !== 16'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", flush_events); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL mw_%0d_ctrl: got %b expected %b", i, ctrl, C_FREEZE); end
      tick();
      checks++; if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL mw_%0d_state: got %0d expected %0d", i, dut.state, MEM_WAIT); end
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_BRANCH) begin errors++; $display("FAIL mw_release_ctrl: got %b expected %b", ctrl, C_BRANCH); end
    tick();
    idle_inputs();
    checks++; if (dut.state !== RUN) begin errors++; $display("FAIL mw_exit_state: got %0d expected %0d", dut.state, RUN); end
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL mw_stall_cnt: got %0d expected 4", stall_cycles); end
    checks++; if (flush_events !== 16'd2) begin errors++; $display("FAIL mw_flush_cnt: got %0d expected 2", flush_events); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mw_no_timeout: got %b expected 0", mem_timeout); end
  endtask

  task automatic test_ready_same_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL rdy0_ctrl: got %b expected %b", ctrl, C_RUN); end
    tick();
    idle_inputs();
    checks++; if (dut.state !== RUN || stall_cycles !== 32'd4) begin
      errors++; $display("FAIL rdy0_state_stall: got state=%0d stall=%0d expected 0 4", dut.state, stall_cycles);
    end
  endtask

  task automatic test_timeout();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL to_%0d_ctrl: got %b expected %b", i, ctrl, C_FREEZE); end
      tick();
      checks++; if (mem_timeout !== (i >= 4)) begin errors++; $display("FAIL to_%0d_flag: got %b expected %b", i, mem_timeout, (i >= 4)); end
    end
    dmem_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (mem_timeout !== 1'b1 || dut.state !== RUN) begin
      errors++; $display("FAIL to_sticky: got to=%b state=%0d expected 1 0", mem_timeout, dut.state);
    end
    checks++; if (stall_cycles !== 32'd14) begin errors++; $display("FAIL to_stall_cnt: got %0d expected 14", stall_cycles); end
  endtask

  task automatic test_reset_mid_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    checks++; if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL rmw_pre_state: got %0d expected %0d", dut.state, MEM_WAIT); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (dut.state !== RUN) begin errors++; $display("FAIL rmw_state: got %0d expected %0d", dut.state, RUN); end
    checks++; if (ctrl !== C_RESET) begin errors++; $display("FAIL rmw_ctrl: got %b expected %b", ctrl, C_RESET); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL rmw_counters: got stall=%0d flush=%0d to=%b expected 0 0 0", stall_cycles, flush_events, mem_timeout);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctrl !== C_LDUSE) begin errors++; $display("FAIL rmw_resume_ctrl: got %b expected %b", ctrl, C_LDUSE); end
    tick();
    idle_inputs();
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL rmw_resume_stall: got %0d expected 1", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_load_use();
    test_mem_wait();
    test_ready_same_cycle();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
